zkbdmus2: RTL and testbench

Parametrised successor to the keyboard/mouse port multiplexer. It holds a double-buffered Spectrum key matrix loaded byte-wise from slavespi and committed atomically, with a watchdog that releases all keys when updates stop. It also accumulates signed mouse deltas into wrapping Kempston counters and stores KJ_NUM joystick channels. It sits between slavespi and zports; its read paths are combinational on zah.

---
 rtl/zkbdmus2_pkg.sv | 21 ++
 rtl/mus_axis_acc.sv | 34 +++
 rtl/zkbdmus2.sv | 134 +++++++++++++
 tb/tb_zkbdmus2.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/zkbdmus2_pkg.sv
// zkbdmus2 shared constants: reset values, port-select bits, limits.
// Imported by zkbdmus2 and mus_axis_acc.
package zkbdmus2_pkg;

    localparam logic [2:0] MUSBTN_RST = 3'b111;
    localparam logic [3:0] WHL_RST    = 4'hF;

    // zah bit picking axis vs buttons, and X vs Y
    localparam int ZAH_AXIS_BIT = 0;
    localparam int ZAH_Y_BIT    = 2;

    localparam int KBD_COLS_MIN = 5;
    localparam int KBD_COLS_MAX = 8;
    localparam int KJ_NUM_MAX   = 4;

    // Counter width able to hold 0..n-1 (at least 1 bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mus_axis_acc.sv
// Load-or-add register for mouse axes and wheel (wraps mod 2^WIDTH).
// Ports: clk, rst_n, stb, delta (1=add, 0=load), din, acc (value).
module mus_axis_acc
    import zkbdmus2_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stb,
    input  logic             delta,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] acc_q, acc_d;

    // Adding the raw pattern mod 2^WIDTH equals adding it sign-extended
    always_comb begin
        acc_d = acc_q;
        if (stb) begin
            acc_d = delta ? acc_q + din : din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= RST_VAL;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/zkbdmus2.sv
// Keyboard matrix (double-buffered, watchdog), Kempston mouse, joysticks.
// Ports: fclk, rst_n, kbd_*, mus_*, kj_*, zah; kbd_data/mus_data/kj_data.
// Optional wheel counter: define ZKBDMUS2_WHEEL_EN.
module zkbdmus2
    import zkbdmus2_pkg::*;
#(
    parameter int KBD_COLS = 5,
    parameter int KBD_TMO  = 0,
    parameter int KJ_NUM   = 1
) (
    input  logic                  fclk,
    input  logic                  rst_n,
    input  logic [7:0]            kbd_in,
    input  logic [2:0]            kbd_in_sel,
    input  logic                  kbd_stb,
    input  logic                  kbd_commit,
    input  logic [7:0]            mus_in,
    input  logic                  mus_delta,
    input  logic                  mus_xstb,
    input  logic                  mus_ystb,
    input  logic                  mus_btnstb,
    input  logic                  kj_stb,
    input  logic [1:0]            kj_sel,
    input  logic [7:0]            zah,
    output logic [KBD_COLS-1:0]   kbd_data,
    output logic [7:0]            mus_data,
    output logic [5*KJ_NUM-1:0]   kj_data
);

    localparam int MW = KBD_COLS * 8;
    localparam int TW = cnt_width(KBD_TMO);
    localparam logic [TW-1:0] WD_LAST =
        TW'((KBD_TMO > 0) ? KBD_TMO - 1 : 0);

    logic [MW-1:0]       shadow_q, shadow_d;
    logic [MW-1:0]       live_q, live_d;
    logic [TW-1:0]       wd_q, wd_d;
    logic                wd_fire;
    logic [2:0]          musbtn_q, musbtn_d;
    logic [5*KJ_NUM-1:0] kj_q, kj_d;
    logic [7:0]          musx, musy;
    logic [3:0]          whl;

    // Shadow write; live takes shadow_d so a same-cycle byte is forwarded
    always_comb begin
        shadow_d = shadow_q;
        if (kbd_stb && (int'(kbd_in_sel) < KBD_COLS)) begin
            shadow_d[int'(kbd_in_sel)*8 +: 8] = kbd_in;
        end
    end

    // Watchdog: count idle cycles, saturate at last, commit wins over clear
    always_comb begin
        wd_d    = wd_q;
        wd_fire = 1'b0;
        if (KBD_TMO > 0) begin
            if (kbd_commit)          wd_d    = '0;
            else if (wd_q == WD_LAST) wd_fire = 1'b1;
            else                     wd_d    = wd_q + TW'(1);
        end
    end

    always_comb begin
        live_d = live_q;
        if (kbd_commit)   live_d = shadow_d;
        else if (wd_fire) live_d = '0;
    end

    always_comb begin
        musbtn_d = musbtn_q;
        if (mus_btnstb) musbtn_d = mus_in[2:0];
    end

    always_comb begin
        kj_d = kj_q;
        if (kj_stb && (int'(kj_sel) < KJ_NUM)) begin
            kj_d[int'(kj_sel)*5 +: 5] = mus_in[4:0];
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            live_q   <= '0;
            wd_q     <= '0;
            musbtn_q <= MUSBTN_RST;
            kj_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            live_q   <= live_d;
            wd_q     <= wd_d;
            musbtn_q <= musbtn_d;
            kj_q     <= kj_d;
        end
    end

    mus_axis_acc #(.WIDTH(8), .RST_VAL(8'h00)) u_x (
        .clk(fclk), .rst_n(rst_n), .stb(mus_xstb),
        .delta(mus_delta), .din(mus_in), .acc(musx)
    );

    mus_axis_acc #(.WIDTH(8), .RST_VAL(8'h00)) u_y (
        .clk(fclk), .rst_n(rst_n), .stb(mus_ystb),
        .delta(mus_delta), .din(mus_in), .acc(musy)
    );

`ifdef ZKBDMUS2_WHEEL_EN
    mus_axis_acc #(.WIDTH(4), .RST_VAL(WHL_RST)) u_whl (
        .clk(fclk), .rst_n(rst_n), .stb(mus_btnstb),
        .delta(mus_delta), .din(mus_in[7:4]), .acc(whl)
    );
`else
    assign whl = WHL_RST;
`endif

    // Column 0 sits at the MSB of kbd_data
    always_comb begin
        kbd_data = '1;
        for (int c = 0; c < KBD_COLS; c++) begin
            for (int r = 0; r < 8; r++) begin
                kbd_data[KBD_COLS-1-c] = kbd_data[KBD_COLS-1-c]
                    & (zah[r] | ~live_q[8*c+r]);
            end
        end
    end

    always_comb begin
        if (zah[ZAH_AXIS_BIT]) mus_data = zah[ZAH_Y_BIT] ? musy : musx;
        else                   mus_data = {whl, 1'b1, musbtn_q};
    end

    assign kj_data = kj_q;

endmodule

// File: tb/tb_zkbdmus2.sv
// Directed self-checking bench for zkbdmus2 (KBD_TMO=16, KJ_NUM=2).
// Expected values are hand-computed constants.
module tb_zkbdmus2;

    logic        fclk = 1'b0;
    logic        rst_n;
    logic [7:0]  kbd_in;
    logic [2:0]  kbd_in_sel;
    logic        kbd_stb, kbd_commit;
    logic [7:0]  mus_in;
    logic        mus_delta, mus_xstb, mus_ystb, mus_btnstb;
    logic        kj_stb;
    logic [1:0]  kj_sel;
    logic [7:0]  zah;
    logic [4:0]  kbd_data;
    logic [7:0]  mus_data;
    logic [9:0]  kj_data;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ZKBDMUS2_WHEEL_EN
    localparam logic [7:0] BTN_DELTA = 8'h1D;
    localparam logic [7:0] BTN_LOAD  = 8'h2D;
`else
    localparam logic [7:0] BTN_DELTA = 8'hFD;
    localparam logic [7:0] BTN_LOAD  = 8'hFD;
`endif

    zkbdmus2 #(.KBD_COLS(5), .KBD_TMO(16), .KJ_NUM(2)) dut (
        .fclk(fclk), .rst_n(rst_n),
        .kbd_in(kbd_in), .kbd_in_sel(kbd_in_sel),
        .kbd_stb(kbd_stb), .kbd_commit(kbd_commit),
        .mus_in(mus_in), .mus_delta(mus_delta),
        .mus_xstb(mus_xstb), .mus_ystb(mus_ystb),
        .mus_btnstb(mus_btnstb),
        .kj_stb(kj_stb), .kj_sel(kj_sel), .zah(zah),
        .kbd_data(kbd_data), .mus_data(mus_data), .kj_data(kj_data)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge fclk);
        #1;
    endtask

    task automatic kbd_rd(input string tag,
                          input logic [7:0] a,
                          input logic [4:0] exp);
        zah = a;
        #1;
        chk(tag, 32'(kbd_data), 32'(exp));
    endtask

    task automatic mus_rd(input string tag,
                          input logic [7:0] a,
                          input logic [7:0] exp);
        zah = a;
        #1;
        chk(tag, 32'(mus_data), 32'(exp));
    endtask

    task automatic kbd_wr(input logic [2:0] sel,
                          input logic [7:0] d,
                          input logic cm);
        kbd_in_sel = sel;
        kbd_in     = d;
        kbd_stb    = 1'b1;
        kbd_commit = cm;
        tick();
        kbd_stb    = 1'b0;
        kbd_commit = 1'b0;
    endtask

    task automatic commit();
        kbd_commit = 1'b1;
        tick();
        kbd_commit = 1'b0;
    endtask

    task automatic mus_wr(input logic dl, input logic [7:0] d,
                          input logic x, input logic y,
                          input logic b);
        mus_delta  = dl;
        mus_in     = d;
        mus_xstb   = x;
        mus_ystb   = y;
        mus_btnstb = b;
        tick();
        mus_xstb   = 1'b0;
        mus_ystb   = 1'b0;
        mus_btnstb = 1'b0;
    endtask

    task automatic kj_wr(input logic [1:0] s, input logic [7:0] d);
        kj_sel = s;
        mus_in = d;
        kj_stb = 1'b1;
        tick();
        kj_stb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        kbd_in = '0; kbd_in_sel = '0; kbd_stb = 0; kbd_commit = 0;
        mus_in = '0; mus_delta = 0; mus_xstb = 0; mus_ystb = 0;
        mus_btnstb = 0; kj_stb = 0; kj_sel = '0; zah = '0;
        tick(3);

        kbd_rd("rst_kbd", 8'h00, 5'b11111);
        mus_rd("rst_btn", 8'hFA, 8'hFF);
        mus_rd("rst_x", 8'hFB, 8'h00);
        mus_rd("rst_y", 8'hFF, 8'h00);
        chk("rst_kj", 32'(kj_data), 32'h0);
        rst_n = 1'b1;
        tick();

        // Key commit
        kbd_wr(3'd0, 8'h01, 1'b0);
        kbd_rd("pre_commit", 8'hFE, 5'b11111);
        commit();
        kbd_rd("commit", 8'hFE, 5'b01111);
        kbd_rd("other_row", 8'hFD, 5'b11111);

        // Same-cycle forward into the committed image
        kbd_wr(3'd4, 8'h80, 1'b1);
        kbd_rd("fwd", 8'h7F, 5'b11110);
        kbd_rd("fwd_both", 8'h7E, 5'b01110);

        // Watchdog releases 16 cycles after commit
        tick(15);
        kbd_rd("wd_hold", 8'h7E, 5'b01110);
        tick();
        kbd_rd("wd_clear", 8'h7E, 5'b11111);

        // Commit while counter at last value keeps keys
        commit();
        kbd_rd("recommit", 8'h00, 5'b01110);
        tick(15);
        commit();
        kbd_rd("wd_saved", 8'h00, 5'b01110);
        tick(15);
        kbd_rd("wd_hold2", 8'h00, 5'b01110);
        tick();
        kbd_rd("wd_clear2", 8'h00, 5'b11111);

        // Out-of-range column select ignored
        kbd_wr(3'd5, 8'hFF, 1'b1);
        kbd_rd("sel_oob", 8'h00, 5'b01110);

        // Mouse axes
        mus_wr(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        mus_rd("x_load", 8'hFB, 8'hFF);
        mus_wr(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        mus_rd("x_wrap", 8'hFB, 8'h01);
        mus_wr(1'b1, 8'hFE, 1'b1, 1'b0, 1'b0);
        mus_rd("x_neg", 8'hFB, 8'hFF);
        mus_wr(1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
        mus_rd("y_load", 8'hFF, 8'h10);
        mus_rd("y_x_kept", 8'hFB, 8'hFF);
        mus_wr(1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        mus_rd("y_add", 8'hFF, 8'h90);
        mus_wr(1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
        mus_rd("xy_x", 8'hFB, 8'h33);
        mus_rd("xy_y", 8'hFF, 8'h33);

        // Buttons and wheel
        mus_wr(1'b1, 8'h25, 1'b0, 1'b0, 1'b1);
        mus_rd("btn_delta", 8'hFA, BTN_DELTA);
        mus_rd("btn_x_kept", 8'hFB, 8'h33);
        mus_wr(1'b0, 8'h25, 1'b0, 1'b0, 1'b1);
        mus_rd("btn_load", 8'hFA, BTN_LOAD);

        // Joysticks
        kj_wr(2'd1, 8'h1F);
        chk("kj1", 32'(kj_data), 32'h3E0);
        kj_wr(2'd3, 8'h05);
        chk("kj_oob", 32'(kj_data), 32'h3E0);
        kj_wr(2'd0, 8'hEA);
        chk("kj0", 32'(kj_data), 32'h3EA);

        // Reset mid-load drops the partial shadow
        kbd_wr(3'd1, 8'hFF, 1'b0);
        rst_n = 1'b0;
        #2;
        mus_rd("rst2_x", 8'hFB, 8'h00);
        chk("rst2_kj", 32'(kj_data), 32'h0);
        rst_n = 1'b1;
        tick();
        commit();
        kbd_rd("rst_midload", 8'h00, 5'b11111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
